// File: rtl/i2s_capture_engine.sv
// -----------------------------------------------------------------------------
// i2s_capture_engine
//
// Captures I2S audio words from the WM8731 ADC path and writes them to an
// external SRAM. All logic runs on the rising edge of the codec bit clock.
//
// Build option:
//   PEAK_METER_EN - when defined, tracks the per-channel peak magnitude of
//                   written words on o_peak_l / o_peak_r. When undefined,
//                   both peak outputs are tied to zero.
//
// Ports:
//   i_BCLK, i_rst       bit clock, asynchronous active-high reset
//   i_ADCLRCK, i_ADCDAT I2S word select (0 = left) and serial data, MSB first
//   i_start, i_stop     one-cycle control pulses (stop wins over start)
//   i_pause             level; holds capture at word boundaries
//   i_mode              00 left, 01 right, 10 stereo, 11 as 00 (latched on start)
//   i_end_addr          last writable address (latched on start)
//   o_SRAM_WE/DATA/ADDR SRAM write port; WE is active low for one cycle
//   o_busy, o_full      status; o_full is sticky until the next start
//   o_done              one-cycle pulse when a capture ends
//   o_words             words written in the current capture
//   o_state             IDLE=0, ARM=1, SHIFT=2, WRITE=3 (DONE reads 0)
//   o_peak_l, o_peak_r  peak magnitudes (see build option)
//
// Handshake: there is no backpressure. A write is presented when o_SRAM_WE is
// low; data and address are register outputs and stable for that whole cycle.
// -----------------------------------------------------------------------------
module i2s_capture_engine #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 20
) (
    input  logic                  i_BCLK,
    input  logic                  i_rst,
    input  logic                  i_ADCLRCK,
    input  logic                  i_ADCDAT,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_pause,
    input  logic [1:0]            i_mode,
    input  logic [ADDR_W-1:0]     i_end_addr,
    output logic                  o_SRAM_WE,
    output logic [SAMPLE_W-1:0]   o_SRAM_DATA,
    output logic [ADDR_W-1:0]     o_SRAM_ADDR,
    output logic                  o_busy,
    output logic                  o_full,
    output logic                  o_done,
    output logic [ADDR_W:0]       o_words,
    output logic [1:0]            o_state,
    output logic [SAMPLE_W-2:0]   o_peak_l,
    output logic [SAMPLE_W-2:0]   o_peak_r
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [1:0] MODE_L  = 2'b00;
    localparam logic [1:0] MODE_R  = 2'b01;
    localparam logic [1:0] MODE_ST = 2'b10;
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                prev_lrck_q;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
    logic                phase_q, phase_d;     // stereo: 0 = left expected next
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic want_right;
    logic edge_hit;
    logic start_ok;

    // Channel currently wanted; during WRITE this is also the channel of the
    // word being written, because the phase only toggles at the end of WRITE.
    assign want_right = (mode_q == MODE_R) || ((mode_q == MODE_ST) && phase_q);
    assign edge_hit   = want_right ? (!prev_lrck_q && i_ADCLRCK)
                                   : (prev_lrck_q && !i_ADCLRCK);
    assign start_ok   = ((state_q == S_IDLE) || (state_q == S_DONE)) && i_start && !i_stop;

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            prev_lrck_q <= 1'b0;
            mode_q      <= MODE_L;
            end_addr_q  <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            phase_q     <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prev_lrck_q <= i_ADCLRCK;
            mode_q      <= mode_d;
            end_addr_q  <= end_addr_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            full_q      <= full_d;
            done_q      <= done_d;
            phase_q     <= phase_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        end_addr_d = end_addr_q;
        addr_d     = addr_q;
        words_d    = words_q;
        full_d     = full_q;
        done_d     = 1'b0;
        phase_d    = phase_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d    = S_ARM;
                    mode_d     = (i_mode == 2'b11) ? MODE_L : i_mode;
                    end_addr_d = i_end_addr;
                    addr_d     = '0;
                    words_d    = '0;
                    full_d     = 1'b0;
                    phase_d    = 1'b0;
                end
            end
            S_ARM: begin
                if (i_stop) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (!i_pause && edge_hit) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    // Partial word is dropped.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    shift_d = {shift_q[SAMPLE_W-2:0], i_ADCDAT};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SAMPLE_W - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The write always completes; a stop only redirects the exit.
                words_d = (words_q == WORDS_MAX) ? words_q : words_q + 1'b1;
                if (addr_q == end_addr_q) begin
                    full_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    phase_d = !phase_q;
                    state_d = i_stop ? S_DONE : S_ARM;
                    done_d  = i_stop;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PEAK_METER_EN
    logic [SAMPLE_W-2:0] peak_l_q, peak_l_d;
    logic [SAMPLE_W-2:0] peak_r_q, peak_r_d;
    logic [SAMPLE_W-1:0] neg_w;
    logic [SAMPLE_W-2:0] mag_w;

    assign neg_w = ~shift_q + SAMPLE_W'(1);

    // Magnitude of the two's complement word; the most negative value
    // has no positive counterpart and saturates to all ones.
    always_comb begin
        mag_w = shift_q[SAMPLE_W-2:0];
        if (shift_q[SAMPLE_W-1]) begin
            if (shift_q[SAMPLE_W-2:0] == '0) mag_w = '1;
            else                             mag_w = neg_w[SAMPLE_W-2:0];
        end
    end

    always_comb begin
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (start_ok) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end else if (state_q == S_WRITE) begin
            if (want_right) begin
                if (mag_w > peak_r_q) peak_r_d = mag_w;
            end else begin
                if (mag_w > peak_l_q) peak_l_d = mag_w;
            end
        end
    end

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        if (i_rst) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign o_peak_l = peak_l_q;
    assign o_peak_r = peak_r_q;
`else
    assign o_peak_l = '0;
    assign o_peak_r = '0;
`endif

    assign o_SRAM_WE   = (state_q != S_WRITE);
    assign o_SRAM_DATA = shift_q;
    assign o_SRAM_ADDR = addr_q;
    assign o_busy      = (state_q == S_ARM) || (state_q == S_SHIFT) || (state_q == S_WRITE);
    assign o_full      = full_q;
    assign o_done      = done_q;
    assign o_words     = words_q;
    assign o_state     = (state_q == S_DONE) ? 2'b00 : state_q[1:0];

endmodule

// File: tb/tb_i2s_capture_engine.sv
module tb_i2s_capture_engine;

  localparam int W  = 16;
  localparam int AW = 20;

  localparam int A_NONE  = 0;
  localparam int A_START = 1;
  localparam int A_STOP  = 2;
  localparam int A_BOTH  = 3;
  localparam int A_RST   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic lrck, dat, start, stop, pause;
  logic [1:0] mode;
  logic [AW-1:0] end_addr;

  logic sram_we;
  logic [W-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic busy, full, done;
  logic [AW:0] words;
  logic [1:0] state;
  logic [W-2:0] peak_l, peak_r;

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_capture_engine #(.SAMPLE_W(W), .ADDR_W(AW)) dut (
    .i_BCLK(clk), .i_rst(rst), .i_ADCLRCK(lrck), .i_ADCDAT(dat),
    .i_start(start), .i_stop(stop), .i_pause(pause), .i_mode(mode),
    .i_end_addr(end_addr),
    .o_SRAM_WE(sram_we), .o_SRAM_DATA(sram_data), .o_SRAM_ADDR(sram_addr),
    .o_busy(busy), .o_full(full), .o_done(done), .o_words(words),
    .o_state(state), .o_peak_l(peak_l), .o_peak_r(peak_r)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level model: each half-frame either is or is not captured, decided
  // at its word-select edge; captured words land at consecutive addresses.
  // Queue entry: {cycle of the write strobe, address, data}.
  logic [63:0] exp_q[$];
  bit m_active = 0;
  int m_mode = 0;
  int m_end = 0;
  int m_addr = 0;
  int m_words = 0;
  bit m_full = 0;
  bit m_phase = 0;
  int m_peak_l = 0;
  int m_peak_r = 0;
  int exp_done = 0;
  int done_cnt = 0;

  function automatic int mag(input logic [W-1:0] w);
    int v;
    v = $signed(w);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic bit wanted(input logic ch);
    if (m_mode == 1) return ch == 1'b1;
    if (m_mode == 2) return ch == m_phase;
    return ch == 1'b0;
  endfunction

  task automatic model_start();
    m_active = 1;
    m_mode = (mode == 2'b11) ? 0 : int'(mode);
    m_end = int'(end_addr);
    m_addr = 0;
    m_words = 0;
    m_full = 0;
    m_phase = 0;
    m_peak_l = 0;
    m_peak_r = 0;
  endtask

  task automatic model_stop();
    if (m_active) begin
      m_active = 0;
      exp_done++;
    end
  endtask

  task automatic model_word(input logic ch, input logic [W-1:0] w, input int e);
    logic [27:0] c;
    logic [AW-1:0] a;
    c = 28'(e + W);
    a = AW'(m_addr);
    exp_q.push_back({c, a, w});
    m_words++;
    if (ch) begin
      if (mag(w) > m_peak_r) m_peak_r = mag(w);
    end else begin
      if (mag(w) > m_peak_l) m_peak_l = mag(w);
    end
    if (m_addr == m_end) begin
      m_full = 1;
      m_active = 0;
      exp_done++;
    end else begin
      m_addr++;
      m_phase = ~m_phase;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] x;
    if (!rst) begin
      if (done) done_cnt++;
      if (!sram_we) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", 64'd1, 64'd0);
        end else begin
          x = exp_q.pop_front();
          chk("we_cycle", 64'(cyc), 64'(x[63:36]));
          chk("wr_addr", 64'(sram_addr), 64'(x[35:16]));
          chk("wr_data", 64'(sram_data), 64'(x[15:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, 64'(sram_we), 64'd1);
    chk({tag, "_data"}, 64'(sram_data), 64'd0);
    chk({tag, "_addr"}, 64'(sram_addr), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_words"}, 64'(words), 64'd0);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_peak_l"}, 64'(peak_l), 64'd0);
    chk({tag, "_peak_r"}, 64'(peak_r), 64'd0);
  endtask

  // One I2S half-frame; the channel is always the opposite of the current one.
  task automatic half_frame(input logic [W-1:0] w, input int len, input int act, input logic pz);
    logic ch;
    bit cap;
    int e;
    ch = ~lrck;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      if (k == 0) begin
        lrck = ch;
        e = cyc + 1;
        cap = m_active && !pause && wanted(ch);
        if (act == A_STOP) model_stop();
        else if (act == A_RST) begin
          m_active = 0; m_addr = 0; m_words = 0; m_full = 0;
          m_peak_l = 0; m_peak_r = 0;
        end else if (cap) model_word(ch, w, e);
      end
      if (k >= 1 && k <= W) dat = w[W-k];
      else dat = 1'($urandom_range(0, 1));
      if (k == 5) pause = pz;
      if (k == 8 && act == A_STOP) stop = 1'b1;
      if (k == 8 && act == A_RST) begin
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid_shift");
      end
      if (k == len - 1 && act == A_RST) rst = 1'b0;
      if (k == len - 2 && act == A_START) begin
        start = 1'b1;
        if (!m_active) model_start();
      end
      if (k == len - 2 && act == A_BOTH) begin
        start = 1'b1;
        stop = 1'b1;
        model_stop();
      end
    end
  endtask

  // Issue a start so that the next half-frame edge enters channel first_ch.
  task automatic start_for(input logic first_ch);
    if (lrck != first_ch) half_frame(16'($urandom), 32, A_NONE, pause);
    half_frame(16'($urandom), 32, A_START, pause);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_words"}, 64'(words), 64'(m_words));
    chk({tag, "_full"}, 64'(full), 64'(m_full));
    chk({tag, "_addr"}, 64'(sram_addr), 64'(m_addr));
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
`ifdef PEAK_METER_EN
    chk({tag, "_peak_l"}, 64'(peak_l), 64'(m_peak_l));
    chk({tag, "_peak_r"}, 64'(peak_r), 64'(m_peak_r));
`else
    chk({tag, "_peak_l"}, 64'(peak_l), 64'd0);
    chk({tag, "_peak_r"}, 64'(peak_r), 64'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; lrck = 1'b0; dat = 1'b0; start = 1'b0; stop = 1'b0;
    pause = 1'b0; mode = 2'b00; end_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Stop and start together from IDLE: stays idle.
    half_frame(16'($urandom), 32, A_BOTH, 1'b0);
    half_frame(16'($urandom), 32, A_NONE, 1'b0);
    check_status("stop_start_idle");

    // Mono-left, two words.
    mode = 2'b00; end_addr = '1;
    start_for(1'b0);
    half_frame(16'h8001, 32, A_NONE, 1'b0);
    half_frame(16'hAAAA, 32, A_NONE, 1'b0);
    half_frame(16'h1234, 32, A_NONE, 1'b0);
    half_frame(16'h5555, 32, A_STOP, 1'b0);
    check_status("mono_left");

    // Peak tracking on left words including the most negative value.
    mode = 2'b11; end_addr = '1;
    start_for(1'b0);
    half_frame(16'h0100, 32, A_NONE, 1'b0);
    half_frame(16'h7000, 32, A_NONE, 1'b0);
    half_frame(16'h8000, 32, A_NONE, 1'b0);
    half_frame(16'h0200, 32, A_NONE, 1'b0);
    half_frame(16'h0010, 32, A_NONE, 1'b0);
    half_frame(16'h0300, 32, A_STOP, 1'b0);
    check_status("peak_left");

    // Stereo, armed just before a right edge: the right word is skipped.
    mode = 2'b10; end_addr = '1;
    start_for(1'b1);
    half_frame(16'hFF00, 32, A_NONE, 1'b0);
    for (int f = 0; f < 3; f++) begin
      half_frame(16'h00FF, 32, A_NONE, 1'b0);
      half_frame(16'hFF00, 32, A_NONE, 1'b0);
    end
    half_frame(16'h00FF, 32, A_STOP, 1'b0);
    check_status("stereo");

    // Mono-right with end address 3: fills and stops by itself.
    mode = 2'b01; end_addr = 20'd3;
    start_for(1'b1);
    for (int h = 0; h < 12; h++) half_frame(16'($urandom), 32, A_NONE, 1'b0);
    check_status("full_right");

    // Stop in the middle of a word.
    mode = 2'b00; end_addr = '1;
    start_for(1'b0);
    half_frame(16'h1111, 32, A_NONE, 1'b0);
    half_frame(16'h2222, 32, A_NONE, 1'b0);
    half_frame(16'h3333, 32, A_STOP, 1'b0);
    check_status("stop_mid_word");

    // Stereo pause: raised while the right word shifts, held two frames.
    mode = 2'b10; end_addr = '1;
    start_for(1'b0);
    half_frame(16'h0A0A, 32, A_NONE, 1'b0);
    half_frame(16'h0B0B, 32, A_NONE, 1'b1);
    half_frame(16'h0C0C, 32, A_NONE, 1'b1);
    half_frame(16'h0D0D, 32, A_NONE, 1'b1);
    half_frame(16'h0E0E, 32, A_NONE, 1'b1);
    half_frame(16'h0F0F, 32, A_NONE, 1'b0);
    half_frame(16'h1A1A, 32, A_NONE, 1'b0);
    half_frame(16'h1B1B, 32, A_NONE, 1'b0);
    half_frame(16'h1C1C, 32, A_STOP, 1'b0);
    check_status("pause");

    // Reset while a word is shifting in.
    mode = 2'b00; end_addr = '1;
    start_for(1'b0);
    half_frame(16'hBEEF, 32, A_RST, 1'b0);
    half_frame(16'h1234, 32, A_NONE, 1'b0);
    check_status("after_rst");

    // Randomized captures.
    for (int it = 0; it < 20; it++) begin
      int n;
      mode = 2'($urandom_range(0, 3));
      end_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 5)) : '1;
      pause = 1'b0;
      start_for(1'($urandom_range(0, 1)));
      n = $urandom_range(4, 12);
      for (int h = 0; h < n; h++)
        half_frame(16'($urandom), $urandom_range(20, 36), A_NONE,
                   ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      pause = 1'b0;
      half_frame(16'($urandom), $urandom_range(20, 36), A_STOP, 1'b0);
      check_status("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
